// File: rtl/dram_page_ctrl.sv
// AHB-slave DRAM page controller: precharge/activate/read/write sequencing with row-hit counting.
// Optional feature: define DRAM_OPEN_ROW_EN to keep the row open between accesses (open-page policy).
module dram_page_ctrl #(
  parameter int ROWADDRWIDTH   = 11,
  parameter int COLADDRWIDTH   = 10,
  parameter int DRAMADDRWIDTH  = 11,
  parameter int T_RP           = 2,
  parameter int T_RCD          = 2,
  parameter int T_CL           = 5,
  parameter int T_WR           = 5,
  parameter int AHB_ADDR_BITS  = 32,
  parameter int AHB_TRANS_BITS = 2,
  parameter int AHB_SIZE_BITS  = 3,
  parameter int AHB_BURST_BITS = 3,
  parameter int AHB_DATA_BITS  = 32,
  parameter int AHB_RESP_BITS  = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL_DRAM,
  input  logic [AHB_ADDR_BITS-1:0]  HADDR,
  input  logic                      HWRITE,
  input  logic [AHB_TRANS_BITS-1:0] HTRANS,
  input  logic [AHB_SIZE_BITS-1:0]  HSIZE,
  input  logic [AHB_BURST_BITS-1:0] HBURST,
  input  logic [AHB_DATA_BITS-1:0]  HWDATA,
  output logic                      HREADY,
  output logic [AHB_RESP_BITS-1:0]  HRESP,
  output logic [AHB_DATA_BITS-1:0]  HRDATA,
  output logic [AHB_DATA_BITS-1:0]  DRAM_in,
  output logic [DRAMADDRWIDTH-1:0]  DRAM_addr,
  output logic                      DRAM_enable_n,
  output logic                      DRAM_write_n,
  output logic                      DRAM_RAS_n,
  output logic                      DRAM_CAS_n,
  input  logic [AHB_DATA_BITS-1:0]  DRAM_out,
  output logic [15:0]               hit_cnt
);

  localparam int CW = 8;
`ifdef DRAM_OPEN_ROW_EN
  localparam bit OPEN_ROW = 1'b1;
`else
  localparam bit OPEN_ROW = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RD, S_WR} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_open;
  logic                    r_pend;
  logic                    r_write;
  logic [ROWADDRWIDTH-1:0] r_row;
  logic [COLADDRWIDTH-1:0] r_col;
  logic [15:0]             r_hit_cnt;

  logic                    w_last;
  logic                    w_accept;
  logic                    w_hit;
  logic [ROWADDRWIDTH-1:0] w_req_row;
  logic [COLADDRWIDTH-1:0] w_req_col;
  logic                    w_unused;

  // HSIZE/HBURST are irrelevant: every access is treated as a single word.
  assign w_unused  = ^{HSIZE, HBURST, HADDR, HTRANS};
  assign w_req_col = HADDR[2 +: COLADDRWIDTH];
  assign w_req_row = HADDR[COLADDRWIDTH+2 +: ROWADDRWIDTH];
  assign w_last    = (r_cnt == CW'(1));
  assign HREADY    = (r_state == S_IDLE) || (((r_state == S_RD) || (r_state == S_WR)) && w_last);
  assign w_accept  = HREADY && HSEL_DRAM && HTRANS[1];
  // r_row always holds the open row while r_open is set.
  assign w_hit     = OPEN_ROW && r_open && (w_req_row == r_row);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_open    <= 1'b0;
      r_pend    <= 1'b0;
      r_write   <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_hit_cnt <= '0;
    end else if (w_accept) begin
      r_row   <= w_req_row;
      r_col   <= w_req_col;
      r_write <= HWRITE;
      if (w_hit) begin
        r_state <= HWRITE ? S_WR : S_RD;
        r_cnt   <= HWRITE ? CW'(T_WR) : CW'(T_CL);
        if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      end else if (r_open) begin
        r_state <= S_PRE;
        r_cnt   <= CW'(T_RP);
        r_pend  <= 1'b1;
        r_open  <= 1'b0;
      end else begin
        r_state <= S_ACT;
        r_cnt   <= CW'(T_RCD);
        r_open  <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_PRE: begin
          if (!w_last) r_cnt <= r_cnt - CW'(1);
          else if (r_pend) begin
            r_state <= S_ACT;
            r_cnt   <= CW'(T_RCD);
            r_pend  <= 1'b0;
            r_open  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        S_ACT: begin
          if (!w_last) r_cnt <= r_cnt - CW'(1);
          else begin
            r_state <= r_write ? S_WR : S_RD;
            r_cnt   <= r_write ? CW'(T_WR) : CW'(T_CL);
          end
        end
        S_RD, S_WR: begin
          if (!w_last) r_cnt <= r_cnt - CW'(1);
          else if (OPEN_ROW) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_state <= S_PRE;
            r_cnt   <= CW'(T_RP);
            r_pend  <= 1'b0;
            r_open  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    DRAM_addr     = '0;
    DRAM_enable_n = 1'b1;
    DRAM_write_n  = 1'b1;
    DRAM_RAS_n    = 1'b1;
    DRAM_CAS_n    = 1'b1;
    case (r_state)
      S_IDLE: begin
        DRAM_enable_n = !r_open;
        DRAM_RAS_n    = !r_open;
      end
      S_PRE: DRAM_enable_n = 1'b0;
      S_ACT: begin
        DRAM_addr     = DRAMADDRWIDTH'(r_row);
        DRAM_enable_n = 1'b0;
        DRAM_RAS_n    = 1'b0;
      end
      S_RD, S_WR: begin
        DRAM_addr     = DRAMADDRWIDTH'(r_col);
        DRAM_enable_n = 1'b0;
        DRAM_RAS_n    = 1'b0;
        DRAM_CAS_n    = 1'b0;
        DRAM_write_n  = (r_state != S_WR);
      end
      default: ;
    endcase
  end

  assign HRESP   = '0;
  assign HRDATA  = ((r_state == S_RD) && w_last) ? DRAM_out : '0;
  assign DRAM_in = (r_state == S_WR) ? HWDATA : '0;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_dram_page_ctrl.sv
// Directed bench for dram_page_ctrl: scoreboarded transfers checked for latency, DRAM command
// phases, data paths and hit counting, plus reset and ignored-transfer cases.
module tb_dram_page_ctrl;
  localparam int T_RP = 2, T_RCD = 2, T_CL = 5, T_WR = 5;
`ifdef DRAM_OPEN_ROW_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL_DRAM = 1'b0, HWRITE = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2, HBURST = '0;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA, DRAM_in, DRAM_out;
  logic [10:0] DRAM_addr;
  logic        DRAM_enable_n, DRAM_write_n, DRAM_RAS_n, DRAM_CAS_n;
  logic [15:0] hit_cnt;

  always #5 HCLK = ~HCLK;
  // Memory model: read data is a fixed pattern keyed by the address on the bus.
  assign DRAM_out = 32'hA5A5_0000 ^ {21'd0, DRAM_addr};

  dram_page_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_DRAM(HSEL_DRAM), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA), .DRAM_in(DRAM_in), .DRAM_addr(DRAM_addr),
    .DRAM_enable_n(DRAM_enable_n), .DRAM_write_n(DRAM_write_n), .DRAM_RAS_n(DRAM_RAS_n),
    .DRAM_CAS_n(DRAM_CAS_n), .DRAM_out(DRAM_out), .hit_cnt(hit_cnt)
  );

  typedef struct {
    int          lat;
    int          act;
    int          pre;
    logic [10:0] row;
    logic [10:0] col;
    logic        wr;
    logic [31:0] data;
    logic [15:0] hits;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  bit          m_open = 1'b0;
  logic [10:0] m_row = '0;
  logic [15:0] m_hits = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {HREADY, HRESP, DRAM_enable_n, DRAM_write_n, DRAM_RAS_n, DRAM_CAS_n, DRAM_addr},
        {1'b1, 2'b00, 4'hF, 11'd0});
    chk({tag, "_data"}, {HRDATA, DRAM_in}, 64'd0);
    chk({tag, "_hit"}, hit_cnt, 16'd0);
  endtask

  // Drives one address phase (caller sits just after an edge), predicts the outcome from the
  // latency rules and the bench's own open-row model.
  task automatic issue(input logic [31:0] addr, input bit wr, input logic [31:0] wdata, input bit push);
    exp_t e;
    int   t;
    for (int i = 0; i < 50 && !HREADY; i++) begin @(posedge HCLK); #1; end
    t     = wr ? T_WR : T_CL;
    e.row = addr[22:12];
    e.col = {1'b0, addr[11:2]};
    e.wr  = wr;
    e.data = wr ? wdata : (32'hA5A5_0000 ^ {22'd0, addr[11:2]});
    if (OPEN && m_open && (e.row == m_row)) begin
      e.lat = t; e.act = 0; e.pre = 0;
      if (m_hits != 16'hFFFF) m_hits++;
    end else if (m_open) begin
      e.lat = T_RP + T_RCD + t; e.act = T_RCD; e.pre = T_RP;
    end else begin
      e.lat = T_RCD + t; e.act = T_RCD; e.pre = 0;
    end
    e.hits = m_hits;
    m_open = OPEN;
    m_row  = e.row;
    HSEL_DRAM = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
    @(posedge HCLK); #1;
    HSEL_DRAM = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = wdata;
    if (push) sb.push_back(e);
  endtask

  // Runs from the first cycle after the address phase to the HREADY completion.
  task automatic wait_done();
    exp_t        e;
    int          n = 1, act = 0, pre = 0, bad = 0;
    logic [10:0] act_row = '0;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      while (!HREADY && n < 60) begin
        if (!DRAM_enable_n && !DRAM_RAS_n && DRAM_CAS_n) begin act++; act_row = DRAM_addr; end
        if (!DRAM_enable_n && DRAM_RAS_n && DRAM_CAS_n) pre++;
        if (HRDATA !== 32'd0) bad++;
        @(posedge HCLK); #1;
        n++;
      end
      chk("latency", n, e.lat);
      chk("act_cycles", act, e.act);
      chk("pre_cycles", pre, e.pre);
      chk("act_row", act_row, e.act != 0 ? e.row : 11'd0);
      chk("hrdata_idle", bad, 0);
      chk("col_addr", DRAM_addr, e.col);
      chk("cas_write", {DRAM_CAS_n, DRAM_write_n}, {1'b0, !e.wr});
      chk("hrdata", HRDATA, e.wr ? 32'd0 : e.data);
      chk("dram_in", DRAM_in, e.wr ? e.data : 32'd0);
      chk("hresp", HRESP, 2'b00);
      chk("hit_cnt", hit_cnt, e.hits);
    end
  endtask

  task automatic pre_tail();
    int n = 0;
    @(posedge HCLK); #1;
    while (!DRAM_enable_n && DRAM_RAS_n && DRAM_CAS_n && n < 20) begin
      n++;
      @(posedge HCLK); #1;
    end
    chk("pre_tail", n, OPEN ? 0 : T_RP);
    chk("tail_idle", {HREADY, DRAM_RAS_n, DRAM_enable_n}, {1'b1, !m_open, !m_open});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge HCLK);
    #1;
    chk_reset_outputs("reset");
    HRESETn = 1'b1;

    issue(32'h0000_1004, 1'b0, 32'd0, 1'b1);        wait_done(); pre_tail();
    issue(32'h0000_1008, 1'b0, 32'd0, 1'b1);        wait_done(); pre_tail();
    issue(32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 1'b1); wait_done(); pre_tail();
    issue(32'h0000_1004, 1'b0, 32'd0, 1'b1);        wait_done(); pre_tail();
    issue(32'h0000_1004, 1'b0, 32'd0, 1'b1);        wait_done(); pre_tail();
`ifdef DRAM_OPEN_ROW_EN
    // Second read is accepted on the first one's completion edge: no idle cycle between them.
    issue(32'h0000_1004, 1'b0, 32'd0, 1'b1); wait_done();
    issue(32'h0000_1008, 1'b0, 32'd0, 1'b1); wait_done(); pre_tail();
`endif

    // IDLE and BUSY transfers, and NONSEQ without select, must leave the controller untouched.
    HADDR = 32'h0000_3000; HSEL_DRAM = 1'b1; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("ign_idle", {HREADY, DRAM_RAS_n, DRAM_enable_n}, {1'b1, !m_open, !m_open});
    HTRANS = 2'b01;
    @(posedge HCLK); #1;
    chk("ign_busy", {HREADY, DRAM_RAS_n, DRAM_enable_n}, {1'b1, !m_open, !m_open});
    HSEL_DRAM = 1'b0; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    chk("ign_nosel", {HREADY, DRAM_RAS_n, DRAM_enable_n}, {1'b1, !m_open, !m_open});
    HTRANS = 2'b00; HADDR = '0;
    issue(32'h0000_1008, 1'b1, 32'h1234_5678, 1'b1); wait_done(); pre_tail();

    // Reset in the third read cycle: the transfer is dropped without a completion.
    issue(32'h0000_2004, 1'b0, 32'd0, 1'b0);
    for (n = 0; n < 30 && DRAM_CAS_n; n++) begin @(posedge HCLK); #1; end
    chk("rd_reached", DRAM_CAS_n, 1'b0);
    repeat (2) begin @(posedge HCLK); #1; end
    chk("mid_rd_hready", {HREADY, DRAM_CAS_n}, {1'b0, 1'b0});
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk_reset_outputs("mid_reset");
    HRESETn = 1'b1;
    m_open = 1'b0;
    m_hits = '0;
    issue(32'h0000_1004, 1'b0, 32'd0, 1'b1); wait_done(); pre_tail();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
